// File: rtl/writeback_unit.sv
// MEM/WB pipeline register and write-back stage: selects ALU result or load data,
// drives the register-file write port and counts retired instructions.
// Optional same-cycle read bypass toward decode is enabled by defining WB_BYPASS_EN.
module writeback_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic              flush,
  input  logic              wb_stall,
  input  logic              mem_reg_write,
  input  logic              mem_mem_to_reg,
  input  logic              mem_reg_dst,
  input  logic [ADDR_W-1:0] mem_rt,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] reg_wr_data,
  output logic              reg_write,
  output logic              wb_valid,
  output logic [CNT_W-1:0]  retired_count
`ifdef WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0] inst_read_reg_addr1,
  input  logic [ADDR_W-1:0] inst_read_reg_addr2,
  output logic              byp_hit1,
  output logic              byp_hit2,
  output logic [DATA_W-1:0] byp_data1,
  output logic [DATA_W-1:0] byp_data2
`endif
);

  localparam logic [ADDR_W-1:0] ZERO_REG = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_flag_q, wr_flag_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              commit;

  assign commit = wb_valid_q & ~wb_stall;

  // Next-state: capture MEM results, or hold on stall (flush still kills in place)
  always_comb begin
    wb_valid_d = wb_valid_q;
    rd_d       = rd_q;
    wr_data_d  = wr_data_q;
    wr_flag_d  = wr_flag_q;
    cnt_d      = cnt_q;

    if (wb_stall) begin
      if (flush) begin
        wb_valid_d = 1'b0;
      end else begin
        wb_valid_d = wb_valid_q;
      end
    end else begin
      wb_valid_d = mem_valid & ~flush;
      wr_flag_d  = mem_reg_write;
      if (mem_reg_dst) begin
        rd_d = mem_rd;
      end else begin
        rd_d = mem_rt;
      end
      if (mem_mem_to_reg) begin
        wr_data_d = mem_rd_data;
      end else begin
        wr_data_d = mem_alu_result;
      end
    end

    // Counter wraps naturally at 2^CNT_W
    if (commit) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State register with synchronous reset that overrides stall and flush
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_q <= 1'b0;
      rd_q       <= ZERO_REG;
      wr_data_q  <= ZERO_DATA;
      wr_flag_q  <= 1'b0;
      cnt_q      <= CNT_ZERO;
    end else begin
      wb_valid_q <= wb_valid_d;
      rd_q       <= rd_d;
      wr_data_q  <= wr_data_d;
      wr_flag_q  <= wr_flag_d;
      cnt_q      <= cnt_d;
    end
  end

  assign wb_valid      = wb_valid_q;
  assign rd            = rd_q;
  assign reg_wr_data   = wr_data_q;
  assign retired_count = cnt_q;
  // $0 is hard-wired zero in the register file, so a write to it is suppressed here
  assign reg_write     = wb_valid_q & wr_flag_q & ~wb_stall & (rd_q != ZERO_REG);

`ifdef WB_BYPASS_EN
  // Same-cycle forwarding of the value being committed to the decode read ports
  always_comb begin
    byp_hit1  = reg_write & (inst_read_reg_addr1 == rd_q);
    byp_hit2  = reg_write & (inst_read_reg_addr2 == rd_q);
    byp_data1 = ZERO_DATA;
    byp_data2 = ZERO_DATA;
    if (byp_hit1) begin
      byp_data1 = wr_data_q;
    end else begin
      byp_data1 = ZERO_DATA;
    end
    if (byp_hit2) begin
      byp_data2 = wr_data_q;
    end else begin
      byp_data2 = ZERO_DATA;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: directed vectors push hand-computed expected
// outputs; a negedge monitor pops and compares them. Counter built with CNT_W=4.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        reset, mem_valid, flush, wb_stall, mem_reg_write, mem_mem_to_reg, mem_reg_dst;
  logic [4:0]  mem_rt, mem_rd;
  logic [31:0] mem_alu_result, mem_rd_data;
  logic [4:0]  rd;
  logic [31:0] reg_wr_data;
  logic        reg_write, wb_valid;
  logic [3:0]  retired_count;
`ifdef WB_BYPASS_EN
  logic [4:0]  addr1 = 5'd5;
  logic [4:0]  addr2 = 5'd6;
  logic        byp_hit1, byp_hit2;
  logic [31:0] byp_data1, byp_data2;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  writeback_unit #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .flush(flush), .wb_stall(wb_stall),
    .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg), .mem_reg_dst(mem_reg_dst),
    .mem_rt(mem_rt), .mem_rd(mem_rd), .mem_alu_result(mem_alu_result), .mem_rd_data(mem_rd_data),
    .rd(rd), .reg_wr_data(reg_wr_data), .reg_write(reg_write), .wb_valid(wb_valid),
    .retired_count(retired_count)
`ifdef WB_BYPASS_EN
    , .inst_read_reg_addr1(addr1), .inst_read_reg_addr2(addr2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2), .byp_data1(byp_data1), .byp_data2(byp_data2)
`endif
  );

  typedef struct packed {
    logic        chk;
    logic        v;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
    logic [3:0]  cnt;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: one expected entry per observed cycle
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.chk) begin
        cmp("wb_valid", {31'd0, wb_valid}, {31'd0, e.v});
        cmp("rd", {27'd0, rd}, {27'd0, e.rd});
        cmp("reg_wr_data", reg_wr_data, e.data);
        cmp("reg_write", {31'd0, reg_write}, {31'd0, e.we});
        cmp("retired_count", {28'd0, retired_count}, {28'd0, e.cnt});
`ifdef WB_BYPASS_EN
        cmp("byp_hit1", {31'd0, byp_hit1}, {31'd0, (e.we && e.rd == 5'd5)});
        cmp("byp_hit2", {31'd0, byp_hit2}, {31'd0, (e.we && e.rd == 5'd6)});
        cmp("byp_data1", byp_data1, (e.we && e.rd == 5'd5) ? e.data : 32'd0);
        cmp("byp_data2", byp_data2, (e.we && e.rd == 5'd6) ? e.data : 32'd0);
`endif
      end
      cyc++;
    end
  end

  // Drive one cycle's inputs and the outputs expected during that same cycle
  task automatic step(input logic r, mv, fl, st, rw, m2r, dst,
                      input logic [4:0] rt_i, rd_i, input logic [31:0] alu, mdat,
                      input logic ck, ev, input logic [4:0] erd, input logic [31:0] edat,
                      input logic ewe, input logic [3:0] ecnt);
    exp_t e;
    reset = r; mem_valid = mv; flush = fl; wb_stall = st; mem_reg_write = rw;
    mem_mem_to_reg = m2r; mem_reg_dst = dst; mem_rt = rt_i; mem_rd = rd_i;
    mem_alu_result = alu; mem_rd_data = mdat;
    e.chk = ck; e.v = ev; e.rd = erd; e.data = edat; e.we = ewe; e.cnt = ecnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; mem_valid = 1'b1; flush = 1'b0; wb_stall = 1'b0; mem_reg_write = 1'b1;
    mem_mem_to_reg = 1'b0; mem_reg_dst = 1'b1; mem_rt = 5'd0; mem_rd = 5'd3;
    mem_alu_result = 32'h1234; mem_rd_data = 32'h5678;
    @(posedge clk);
    #1;
    //   r  mv fl st rw m2r dst rt  rd   alu           mdat            ck v  rd  data           we cnt
    step(1, 1, 0, 0, 1, 0, 1, 0, 3, 32'h1234, 32'h5678, 0, 0, 0, 32'h0, 0, 0);
    step(1, 1, 0, 0, 1, 0, 1, 0, 3, 32'h1234, 32'h5678, 1, 0, 0, 32'h0, 0, 0);
    step(1, 1, 0, 0, 1, 0, 1, 0, 3, 32'h1234, 32'h5678, 1, 0, 0, 32'h0, 0, 0);
    // ALU op rd=2 <- 25
    step(0, 1, 0, 0, 1, 0, 1, 9, 2, 32'd25, 32'h55, 1, 0, 0, 32'h0, 0, 0);
    // Load rt=7 <- DEADBEEF
    step(0, 1, 0, 0, 1, 1, 0, 7, 3, 32'h100, 32'hDEADBEEF, 1, 1, 2, 32'd25, 1, 0);
    // Destination $0
    step(0, 1, 0, 0, 1, 0, 1, 4, 0, 32'h77, 32'h0, 1, 1, 7, 32'hDEADBEEF, 1, 1);
    // Bubble (mem_valid=0)
    step(0, 0, 0, 0, 1, 0, 1, 0, 9, 32'h99, 32'h0, 1, 1, 0, 32'h77, 0, 2);
    // Flush
    step(0, 1, 1, 0, 1, 0, 1, 0, 10, 32'hAA, 32'h0, 1, 0, 9, 32'h99, 0, 3);
    step(0, 1, 0, 0, 1, 0, 1, 0, 4, 32'h44, 32'h0, 1, 0, 10, 32'hAA, 0, 3);
    // Stall 4 cycles with fresh MEM inputs
    step(0, 1, 0, 1, 1, 0, 1, 0, 11, 32'hBB, 32'h0, 1, 1, 4, 32'h44, 0, 3);
    step(0, 1, 0, 1, 1, 1, 1, 0, 12, 32'hCC, 32'hC1, 1, 1, 4, 32'h44, 0, 3);
    step(0, 1, 0, 1, 0, 0, 0, 13, 0, 32'hDD, 32'h0, 1, 1, 4, 32'h44, 0, 3);
    step(0, 1, 0, 1, 1, 0, 1, 0, 14, 32'hEE, 32'h0, 1, 1, 4, 32'h44, 0, 3);
    // Release: held instruction commits once
    step(0, 1, 0, 0, 1, 0, 1, 0, 5, 32'd42, 32'h0, 1, 1, 4, 32'h44, 1, 3);
    step(0, 1, 0, 0, 1, 0, 1, 0, 6, 32'h66, 32'h0, 1, 1, 5, 32'd42, 1, 4);
    // Stall + flush kills in place
    step(0, 1, 1, 1, 1, 0, 1, 0, 8, 32'h88, 32'h0, 1, 1, 6, 32'h66, 0, 5);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 6, 32'h66, 0, 5);
    // Mid-operation reset overrides stall
    step(1, 1, 0, 1, 1, 0, 1, 0, 3, 32'h33, 32'h0, 1, 0, 0, 32'h0, 0, 5);
    // 17 commits wrap the 4-bit counter to 1
    for (int k = 0; k < 17; k++) begin
      if (k == 0)
        step(0, 1, 0, 0, 1, 0, 1, 0, 1, 32'd0, 32'h0, 1, 0, 0, 32'h0, 0, 0);
      else
        step(0, 1, 0, 0, 1, 0, 1, 0, 1, k, 32'h0, 1, 1, 1, k - 1, 1, 4'(k - 1));
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 1, 1, 32'd16, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h0, 0, 1);

    for (int w = 0; w < 5 && sb_q.size() > 0; w++) @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
